instr_mem_prog: RTL and testbench

//  Parametrised, loadable instruction memory for the single-cycle CPU.

---
 rtl/instr_mem_prog.sv | 153 +++++++++++++++
 tb/tb_instr_mem_prog.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_prog.sv
// Loadable instruction memory for the single-cycle CPU.
// A streaming programming port fills the RAM sequentially from word 0. Once the
// program is in place, the fetch port serves byte-addressed, word-aligned reads
// with one cycle of latency. Misaligned fetches and fetches past the loaded
// program are flagged as faults.
module instr_mem_prog #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 128,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD    = 32'hE1A00000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fetch_req,
  input  logic [ADDR_WIDTH-1:0]        fetch_addr,
  output logic [DATA_WIDTH-1:0]        fetch_data,
  output logic                         fetch_valid,
  output logic                         fetch_fault,
  input  logic                         prog_start,
  input  logic                         prog_valid,
  input  logic [DATA_WIDTH-1:0]        prog_data,
  input  logic                         prog_last,
  output logic                         prog_ready,
  output logic                         loaded,
  output logic [$clog2(DEPTH_WORDS):0] prog_count
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam int TAG_W = ADDR_WIDTH - 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    RUN
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] fetchData_q;
  logic                  fetchValid_q;
  logic                  fetchFault_q;

  // Storage is deliberately not reset: words beyond prog_count can never be read.
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic             accept;
  logic [IDX_W-1:0] wordIdx;
  logic [TAG_W-1:0] wordAddr;
  logic             fault;

  // A new load request always wins over a word presented in the same cycle.
  assign accept   = prog_valid && (state_q == LOAD) && !prog_start;
  assign wordIdx  = fetch_addr[IDX_W+1:2];
  assign wordAddr = fetch_addr[ADDR_WIDTH-1:2];
  // The range check uses the full word address, so high address bits that would
  // alias into the array still fault.
  assign fault    = (fetch_addr[1:0] != 2'b00) || (wordAddr >= TAG_W'(count_q));

  assign prog_ready  = (state_q == LOAD);
  assign loaded      = (state_q == RUN);
  assign prog_count  = count_q;
  assign fetch_data  = fetchData_q;
  assign fetch_valid = fetchValid_q;
  assign fetch_fault = fetchFault_q;

  // State, write pointer and word count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Load sequencing: prog_start (re)opens a load from word 0, and the load closes
  // on the word flagged last or when the final array slot has been written.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    case (state_q)
      EMPTY: begin
        if (prog_start) begin
          state_d = LOAD;
          ptr_d   = '0;
          count_d = '0;
        end
      end
      LOAD: begin
        if (prog_start) begin
          ptr_d   = '0;
          count_d = '0;
        end else if (accept) begin
          ptr_d   = ptr_q + IDX_W'(1);
          count_d = count_q + CNT_W'(1);
          if (prog_last || (ptr_q == LAST_IDX)) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (prog_start) begin
          state_d = LOAD;
          ptr_d   = '0;
          count_d = '0;
        end
      end
      default: begin
        state_d = EMPTY;
        ptr_d   = '0;
        count_d = '0;
      end
    endcase
  end

  // Program words are written only while loading, so they never collide with a read.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[ptr_q] <= prog_data;
    end
  end

  // Registered fetch response; data and fault hold their last values between requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetchData_q  <= NOP_WORD;
      fetchValid_q <= 1'b0;
      fetchFault_q <= 1'b0;
    end else begin
      fetchValid_q <= fetch_req;
      if (fetch_req) begin
        if (state_q != RUN) begin
          fetchData_q  <= NOP_WORD;
          fetchFault_q <= 1'b0;
        end else if (fault) begin
          fetchData_q  <= NOP_WORD;
          fetchFault_q <= 1'b1;
        end else begin
          fetchData_q  <= mem[wordIdx];
          fetchFault_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_prog.sv
// Self-checking bench for instr_mem_prog: directed scenarios followed by random
// traffic, all compared against a queue-based model of the loaded program.
module tb_instr_mem_prog;

  localparam int          DEPTH = 128;
  localparam logic [31:0] NOP   = 32'hE1A00000;

  logic        clk;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_valid;
  logic        fetch_fault;
  logic        prog_start;
  logic        prog_valid;
  logic [31:0] prog_data;
  logic        prog_last;
  logic        prog_ready;
  logic        loaded;
  logic [7:0]  prog_count;

  instr_mem_prog #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH_WORDS(DEPTH),
    .NOP_WORD   (NOP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .fetch_valid(fetch_valid),
    .fetch_fault(fetch_fault),
    .prog_start (prog_start),
    .prog_valid (prog_valid),
    .prog_data  (prog_data),
    .prog_last  (prog_last),
    .prog_ready (prog_ready),
    .loaded     (loaded),
    .prog_count (prog_count)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    assertCount = 0;
  int    failCount   = 0;
  string phase       = "init";

  // Reference model: the program is simply the list of words accepted so far.
  logic [31:0] progQ[$];
  bit          modelLoading = 0;
  bit          modelLoaded  = 0;
  logic [31:0] expData      = NOP;
  bit          expValid     = 0;
  bit          expFault     = 0;

  // Single point of comparison: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s/%s: got 0x%0h, expected 0x%0h (t=%0t)",
               phase, tag, observed, expected, $time);
    end
  endtask

  // Compares every observable output with the model's view of the block.
  task automatic checkAll();
    checkOutput("fetch_valid", 64'(fetch_valid), 64'(expValid));
    checkOutput("fetch_data",  64'(fetch_data),  64'(expData));
    checkOutput("fetch_fault", 64'(fetch_fault), 64'(expFault));
    checkOutput("prog_ready",  64'(prog_ready),  64'(modelLoading));
    checkOutput("loaded",      64'(loaded),      64'(modelLoaded));
    checkOutput("prog_count",  64'(prog_count),  64'(progQ.size()));
  endtask

  // Drives one clock cycle of inputs, advances the model and checks the result.
  task automatic applyStimulus(input bit req, input logic [31:0] addr, input bit start,
                               input bit valid, input bit last, input logic [31:0] data);
    fetch_req  = req;
    fetch_addr = addr;
    prog_start = start;
    prog_valid = valid;
    prog_last  = last;
    prog_data  = data;
    expValid = req;
    if (req) begin
      if (!modelLoaded) begin
        expData  = NOP;
        expFault = 0;
      end else if ((addr % 4) != 0 || (addr / 4) >= progQ.size()) begin
        expData  = NOP;
        expFault = 1;
      end else begin
        expData  = progQ[addr / 4];
        expFault = 0;
      end
    end
    if (start) begin
      progQ.delete();
      modelLoading = 1;
      modelLoaded  = 0;
    end else if (valid && modelLoading) begin
      progQ.push_back(data);
      if (last || progQ.size() == DEPTH) begin
        modelLoading = 0;
        modelLoaded  = 1;
      end
    end
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic idle();
    applyStimulus(0, 32'h0, 0, 0, 0, 32'h0);
  endtask

  task automatic fetch(input logic [31:0] addr);
    applyStimulus(1, addr, 0, 0, 0, 32'h0);
  endtask

  task automatic pushWord(input logic [31:0] data, input bit last);
    applyStimulus(0, 32'h0, 0, 1, last, data);
  endtask

  // Asserts reset between edges and checks that it takes effect immediately.
  task automatic applyReset();
    fetch_req  = 0;
    fetch_addr = 0;
    prog_start = 0;
    prog_valid = 0;
    prog_last  = 0;
    prog_data  = 0;
    reset      = 1;
    #2;
    progQ.delete();
    modelLoading = 0;
    modelLoaded  = 0;
    expData      = NOP;
    expValid     = 0;
    expFault     = 0;
    checkAll();
    @(posedge clk);
    #1;
    checkAll();
    reset = 0;
  endtask

  // Address mix: mostly aligned near the program, some misaligned, some huge.
  function automatic logic [31:0] randAddr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return $urandom;
    if (r < 3)  return $urandom_range(0, DEPTH * 4 + 15);
    return $urandom_range(0, DEPTH + 3) << 2;
  endfunction

  logic [31:0] word127;

  // Directed scenarios followed by randomised traffic.
  initial begin
    reset = 1;
    fetch_req = 0; fetch_addr = 0;
    prog_start = 0; prog_valid = 0; prog_last = 0; prog_data = 0;

    phase = "reset";
    applyReset();
    checkOutput("rst_data", 64'(fetch_data), 64'(NOP));

    phase = "empty";
    fetch(32'h0);
    checkOutput("empty_valid", 64'(fetch_valid), 64'd1);
    checkOutput("empty_fault", 64'(fetch_fault), 64'd0);
    pushWord(32'hDEADBEEF, 1);
    idle();

    phase = "twoword";
    applyStimulus(0, 0, 1, 0, 0, 0);
    pushWord(32'hE2811002, 0);
    pushWord(32'hE2822003, 1);
    checkOutput("tw_loaded", 64'(loaded), 64'd1);
    checkOutput("tw_count",  64'(prog_count), 64'd2);
    fetch(32'h4);
    checkOutput("tw_word1", 64'(fetch_data), 64'hE2822003);
    fetch(32'h0);
    fetch(32'h8);
    checkOutput("tw_range", 64'(fetch_fault), 64'd1);
    fetch(32'h2);
    checkOutput("tw_align", 64'(fetch_data), 64'(NOP));
    idle();
    idle();

    phase = "drop";
    applyStimulus(0, 0, 1, 0, 0, 0);
    pushWord(32'hAAAA0000, 0);
    applyStimulus(1, 32'h0, 1, 1, 0, 32'hBBBB1111);
    checkOutput("drop_count", 64'(prog_count), 64'd0);
    pushWord(32'h11111111, 0);
    pushWord(32'h22222222, 1);
    fetch(32'h0);
    checkOutput("drop_idx0", 64'(fetch_data), 64'h11111111);

    phase = "full";
    applyStimulus(0, 0, 1, 0, 0, 0);
    word127 = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      prog_data = $urandom;
      if (i == DEPTH - 1) word127 = prog_data;
      pushWord(prog_data, 0);
    end
    checkOutput("full_count", 64'(prog_count), 64'd128);
    checkOutput("full_ready", 64'(prog_ready), 64'd0);
    pushWord(32'h55555555, 1);
    fetch(32'h1FC);
    checkOutput("full_last", 64'(fetch_data), 64'(word127));
    fetch(32'h200);
    checkOutput("full_over", 64'(fetch_fault), 64'd1);
    fetch(32'h80000004);
    for (int i = 0; i < 20; i++) fetch(randAddr());

    phase = "midreset";
    applyStimulus(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) pushWord($urandom, 0);
    fetch(32'h0);
    applyReset();
    checkOutput("mr_count", 64'(prog_count), 64'd0);
    fetch(32'h0);
    checkOutput("mr_data",  64'(fetch_data), 64'(NOP));
    checkOutput("mr_fault", 64'(fetch_fault), 64'd0);

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        applyReset();
      end else begin
        applyStimulus($urandom_range(0, 1), randAddr(), $urandom_range(0, 39) == 0,
                      $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, $urandom);
      end
    end

    phase = "done";
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
